// File: rtl/lab2_proc_alu_share_arb_if.sv
// Bundle of the handshake and ALU-side signals of the shared-ALU arbiter.
//   req0/req1  : val/rdy request channels, msg = {fn[67:64], in0[63:32], in1[31:0]}
//   resp0/resp1: val/rdy response channels, msg = {ops_ltu, ops_lt, ops_eq, out[31:0]}
//   alu_*      : registered operands out to the external ALU, combinational result back
// modport slave  : the arbiter's view
// modport master : the requesters' / ALU's view (testbench side)
interface lab2_proc_alu_share_arb_if;
    logic        req0_val;
    logic        req0_rdy;
    logic [67:0] req0_msg;
    logic        req1_val;
    logic        req1_rdy;
    logic [67:0] req1_msg;
    logic        resp0_val;
    logic        resp0_rdy;
    logic [34:0] resp0_msg;
    logic        resp1_val;
    logic        resp1_rdy;
    logic [34:0] resp1_msg;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [3:0]  alu_fn;
    logic [31:0] alu_out;
    logic        alu_ops_eq;
    logic        alu_ops_lt;
    logic        alu_ops_ltu;

    modport slave (
        input  req0_val, req0_msg, req1_val, req1_msg,
        input  resp0_rdy, resp1_rdy,
        input  alu_out, alu_ops_eq, alu_ops_lt, alu_ops_ltu,
        output req0_rdy, req1_rdy,
        output resp0_val, resp0_msg, resp1_val, resp1_msg,
        output alu_in0, alu_in1, alu_fn
    );

    modport master (
        output req0_val, req0_msg, req1_val, req1_msg,
        output resp0_rdy, resp1_rdy,
        output alu_out, alu_ops_eq, alu_ops_lt, alu_ops_ltu,
        input  req0_rdy, req1_rdy,
        input  resp0_val, resp0_msg, resp1_val, resp1_msg,
        input  alu_in0, alu_in1, alu_fn
    );
endinterface

// File: rtl/lab2_proc_alu_share_arb.sv
// Shares one 32-bit ALU between two val/rdy requesters with round-robin grant and a
// single operation in flight. Operands are captured on accept and drive the ALU; the
// ALU result and flags are returned on the owning requester's response channel one
// cycle after accept. A response handshake and a new accept may occur in the same
// cycle, sustaining one operation per cycle.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : lab2_proc_alu_share_arb_if.slave (request, response and ALU signals)
module lab2_proc_alu_share_arb #(
    parameter logic p_rr_init = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    lab2_proc_alu_share_arb_if.slave      bus
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RESP = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  fn_q, fn_d;
    logic [31:0] in0_q, in0_d;
    logic [31:0] in1_q, in1_d;

    logic        resp_fire_s;
    logic        can_accept_s;
    logic        grant_val_s;
    logic        grant_id_s;
    logic        accept_s;
    logic [67:0] grant_msg_s;

    // Owner's response handshake completes this cycle.
    always_comb begin
        resp_fire_s = 1'b0;
        if (state_q == STATE_RESP) begin
            resp_fire_s = owner_q ? bus.resp1_rdy : bus.resp0_rdy;
        end else begin
            resp_fire_s = 1'b0;
        end
    end

    // Free slot now, or one that is freed by this cycle's response handshake.
    assign can_accept_s = (state_q == STATE_IDLE) | resp_fire_s;

    // Arbitration: a lone requester wins; on contention the round-robin pointer decides.
    always_comb begin
        grant_val_s = 1'b0;
        grant_id_s  = 1'b0;
        case ({bus.req1_val, bus.req0_val})
            2'b01: begin
                grant_val_s = 1'b1;
                grant_id_s  = 1'b0;
            end
            2'b10: begin
                grant_val_s = 1'b1;
                grant_id_s  = 1'b1;
            end
            2'b11: begin
                grant_val_s = 1'b1;
                grant_id_s  = rr_ptr_q;
            end
            default: begin
                grant_val_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        endcase
    end

    assign accept_s    = can_accept_s & grant_val_s;
    assign grant_msg_s = grant_id_s ? bus.req1_msg : bus.req0_msg;

    // Ready is combinational on the response-side rdy so back-to-back ops need no bubble.
    assign bus.req0_rdy = accept_s & ~grant_id_s;
    assign bus.req1_rdy = accept_s &  grant_id_s;

    // Next-state: capture on accept, otherwise retire on response or hold.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        fn_d     = fn_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        if (accept_s) begin
            state_d  = STATE_RESP;
            owner_d  = grant_id_s;
            rr_ptr_d = ~grant_id_s;
            fn_d     = grant_msg_s[67:64];
            in0_d    = grant_msg_s[63:32];
            in1_d    = grant_msg_s[31:0];
        end else if (resp_fire_s) begin
            state_d  = STATE_IDLE;
        end else begin
            state_d  = state_q;
        end
    end

    // State and operand registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            rr_ptr_q <= p_rr_init;
            owner_q  <= 1'b0;
            fn_q     <= 4'd0;
            in0_q    <= 32'd0;
            in1_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            fn_q     <= fn_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
        end
    end

    // The ALU always sees the captured operands; in IDLE they are stale and unused.
    assign bus.alu_in0 = in0_q;
    assign bus.alu_in1 = in1_q;
    assign bus.alu_fn  = fn_q;

    // Response is routed only to the owner; the other channel stays quiet with a zero msg.
    always_comb begin
        bus.resp0_val = 1'b0;
        bus.resp1_val = 1'b0;
        bus.resp0_msg = 35'd0;
        bus.resp1_msg = 35'd0;
        if (state_q == STATE_RESP) begin
            if (owner_q) begin
                bus.resp1_val = 1'b1;
                bus.resp1_msg = {bus.alu_ops_ltu, bus.alu_ops_lt, bus.alu_ops_eq, bus.alu_out};
            end else begin
                bus.resp0_val = 1'b1;
                bus.resp0_msg = {bus.alu_ops_ltu, bus.alu_ops_lt, bus.alu_ops_eq, bus.alu_out};
            end
        end else begin
            bus.resp0_val = 1'b0;
            bus.resp1_val = 1'b0;
        end
    end

endmodule
